// File: rtl/demorgan_pkg.sv
// Shared types for the De Morgan pipeline: operation encoding and op classification.
package demorgan_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOT_A  = 3'd0,
        OP_NOT_B  = 3'd1,
        OP_NOR_C  = 3'd2,
        OP_NOR_G  = 3'd3,
        OP_NAND_C = 3'd4,
        OP_NAND_G = 3'd5,
        OP_AND    = 3'd6,
        OP_OR     = 3'd7
    } op_e;

    // Ops whose result has two equivalent forms that can be cross-checked.
    function automatic logic is_demorgan_op(input op_e op);
        return (op == OP_NOR_C) || (op == OP_NOR_G) || (op == OP_NAND_C) || (op == OP_NAND_G);
    endfunction

endpackage

// File: rtl/demorgan_lane.sv
// One bit of the result: complemented-input form (c) and gate form (g) for the selected op.
module demorgan_lane
    import demorgan_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic na,
    input  logic nb,
    input  op_e  op,
    output logic c,
    output logic g
);

    // Non-De Morgan ops drive the same value on both forms.
    always_comb begin
        c = 1'b0;
        g = 1'b0;
        case (op)
            OP_NOT_A:             begin c = na;       g = na;       end
            OP_NOT_B:             begin c = nb;       g = nb;       end
            OP_NOR_C,  OP_NOR_G:  begin c = na & nb;  g = ~(a | b); end
            OP_NAND_C, OP_NAND_G: begin c = na | nb;  g = ~(a & b); end
            OP_AND:               begin c = a & b;    g = a & b;    end
            OP_OR:                begin c = a | b;    g = a | b;    end
            default:              begin c = 1'b0;     g = 1'b0;     end
        endcase
    end

endmodule

// File: rtl/demorgan_pipe.sv
// Two-stage valid/ready pipeline computing bitwise logic ops with De Morgan cross-check
// and a saturating mismatch counter.
module demorgan_pipe
    import demorgan_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             inject_fault,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_ok,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky,
    input  logic             clr_count
);

    logic             s1Valid;
    logic [WIDTH-1:0] s1A, s1B, s1NA, s1NB;
    op_e              s1Op;
    logic             s1En, s2En;
    logic [WIDTH-1:0] formC, formG, gFault, resultY;
    logic             resultOk;

    // No skid buffer: ready ripples back combinationally from the consumer.
    assign s2En     = !out_valid || out_ready;
    assign s1En     = !s1Valid || s2En;
    assign in_ready = s1En;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1A     <= '0;
            s1B     <= '0;
            s1NA    <= '0;
            s1NB    <= '0;
            s1Op    <= OP_NOT_A;
        end else if (s1En) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1A  <= in_a;
                s1B  <= in_b;
                s1NA <= ~in_a;
                s1NB <= ~in_b;
                s1Op <= op_e'(in_op);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gLane
        demorgan_lane uLane (
            .a  (s1A[i]),
            .b  (s1B[i]),
            .na (s1NA[i]),
            .nb (s1NB[i]),
            .op (s1Op),
            .c  (formC[i]),
            .g  (formG[i])
        );
    end

    // Fault hook perturbs only the gate form, so it shows up as a form mismatch.
    assign gFault = formG ^ WIDTH'(inject_fault);

    always_comb begin
        resultY  = formC;
        resultOk = 1'b1;
        if (is_demorgan_op(s1Op)) begin
            resultOk = (formC == gFault);
            if ((s1Op == OP_NOR_G) || (s1Op == OP_NAND_G)) begin
                resultY = gFault;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
            out_ok    <= 1'b1;
        end else if (s2En) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                out_y  <= resultY;
                out_ok <= resultOk;
            end
        end
    end

    // Clear takes priority over a same-cycle mismatch transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (clr_count) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (out_valid && out_ready && !out_ok) begin
            err_sticky <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demorgan_pipe.sv
// Scoreboard bench for demorgan_pipe: stimulus pushes hand-computed results, a monitor pops on transfer.
module tb_demorgan_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             inject_fault;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_ok;
    logic [CNT_W-1:0] err_count;
    logic             err_sticky;
    logic             clr_count;

    int checks = 0;
    int passed = 0;
    logic [WIDTH:0] scb[$];

    demorgan_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_op        (in_op),
        .inject_fault (inject_fault),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_y        (out_y),
        .out_ok       (out_ok),
        .err_count    (err_count),
        .err_sticky   (err_sticky),
        .clr_count    (clr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every transfer must match the oldest expected entry.
    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (scb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got y=0x%0h ok=%0b expected none at %0t", out_y, out_ok, $time);
                end else begin
                    e = scb.pop_front();
                    check("out_y", 32'(out_y), 32'(e[WIDTH-1:0]));
                    check("out_ok", 32'(out_ok), 32'(e[WIDTH]));
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] expY, input logic expOk);
        bit accepted = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                scb.push_back({expOk, expY});
                accepted = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for op %0d", op);
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(posedge clk); #2;
            if (scb.size() == 0 && !out_valid) done = 1;
        end
        checks++;
        if (done) passed++;
        else $display("FAIL drain_timeout: got %0d pending expected 0", scb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] opsY[8];
        opsY = '{8'h5A, 8'hC3, 8'h42, 8'h42, 8'hDB, 8'hDB, 8'h24, 8'hBD};

        // Reset held with a valid offer: nothing accepted.
        rst_n = 1'b0; in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_op = 3'd6;
        inject_fault = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_ok", 32'(out_ok), 32'd1);
        check("rst_out_y", 32'(out_y), 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("post_rst_no_item", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Latency: accepted at edge E0, visible after E1.
        send(8'hA5, 8'h3C, 3'd7, 8'hBD, 1'b1);
        @(negedge clk);
        check("latency_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("latency_2cyc", 32'(out_valid), 32'd1);
        drain();

        // All ops back-to-back at full throughput.
        for (int op = 0; op < 8; op++) send(8'hA5, 8'h3C, 3'(op), opsY[op], 1'b1);
        drain();

        // Backpressure: two accepted, third stalls with output held.
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 3'd6, 8'h30, 1'b1);
        send(8'hF0, 8'h0F, 3'd7, 8'hFF, 1'b1);
        in_a = 8'h12; in_b = 8'h00; in_op = 3'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_y", 32'(out_y), 32'h30);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(8'h12, 8'h00, 3'd0, 8'hED, 1'b1);
        drain();

        // Fault injection and counter saturation.
        inject_fault = 1'b1;
        send(8'h00, 8'h00, 3'd3, 8'hFE, 1'b0);
        drain();
        check("fault_err_count", 32'(err_count), 32'd1);
        check("fault_err_sticky", 32'(err_sticky), 32'd1);
        send(8'h00, 8'h00, 3'd3, 8'hFE, 1'b0);
        send(8'h00, 8'h00, 3'd2, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 3'd5, 8'h01, 1'b0);
        send(8'hFF, 8'hFF, 3'd4, 8'h00, 1'b0);
        send(8'hFF, 8'h0F, 3'd6, 8'h0F, 1'b1);
        drain();
        check("sat_err_count", 32'(err_count), 32'd3);
        check("sat_err_sticky", 32'(err_sticky), 32'd1);

        // Clear on the same edge as a mismatch transfer.
        send(8'h00, 8'h00, 3'd3, 8'hFE, 1'b0);
        @(posedge clk); #1 clr_count = 1'b1;
        @(negedge clk);
        check("race_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 clr_count = 1'b0;
        check("race_err_count", 32'(err_count), 32'd0);
        check("race_err_sticky", 32'(err_sticky), 32'd0);
        drain();
        inject_fault = 1'b0;

        // Reset during a stall discards in-flight items.
        out_ready = 1'b0;
        send(8'hF0, 8'h3C, 3'd6, 8'h30, 1'b1);
        send(8'hF0, 8'h0F, 3'd7, 8'hFF, 1'b1);
        @(negedge clk);
        check("midstall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        scb.delete();
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_y", 32'(out_y), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("no_stale_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send(8'h00, 8'h3C, 3'd1, 8'hC3, 1'b1);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
